// File: rtl/mux_2x1_arbiter_pkg.sv
// Shared definitions for the two-channel round-robin mux arbiter.
// Channel ids, output-register state encoding and the grant helper.
package mux_2x1_arbiter_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic active;
        logic ch;
    } grant_t;

    // Round-robin pick: a lone requester wins outright, a tie goes to
    // the channel that did not win last time.
    function automatic grant_t pick_grant(
        input logic v0,
        input logic v1,
        input logic last
    );
        grant_t g;
        g.active = 1'b0;
        g.ch     = CH0;
        unique case ({v1, v0})
            2'b01: begin
                g.active = 1'b1;
                g.ch     = CH0;
            end
            2'b10: begin
                g.active = 1'b1;
                g.ch     = CH1;
            end
            2'b11: begin
                g.active = 1'b1;
                g.ch     = ~last;
            end
            default: begin
                g.active = 1'b0;
                g.ch     = CH0;
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mux_2x1_mux.sv
// Shared 2:1 datapath mux with enable.
// Output is forced to zero while disabled so no stale data leaks out.
module mux_2x1
    import mux_2x1_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    input  logic             enable,
    output logic [WIDTH-1:0] out
);

    // Select in1 for channel 0, in2 for channel 1, zero when idle.
    always_comb begin
        out = '0;
        if (enable) begin
            out = (sel == CH1) ? in2 : in1;
        end
    end

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter sharing one mux_2x1 between two valid/ready
// producers, feeding a single-entry registered output with counters.
module mux_2x1_arbiter
    import mux_2x1_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             load_ok;
    grant_t           gnt;
    logic             grant;
    logic             grant_active;
    logic [WIDTH-1:0] mux_out;

    // Decide whether the output register can take a word and who wins.
    always_comb begin
        load_ok      = 1'b0;
        grant        = CH0;
        grant_active = 1'b0;
        gnt          = pick_grant(in0_valid, in1_valid, last_grant_q);
        if (!rst) begin
            load_ok = (state_q == EMPTY) || out_ready;
        end
        if (load_ok) begin
            grant        = gnt.ch;
            grant_active = gnt.active;
        end
    end

    assign in0_ready = grant_active && (grant == CH0);
    assign in1_ready = grant_active && (grant == CH1);

    mux_2x1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in1    (in0_data),
        .in2    (in1_data),
        .sel    (grant),
        .enable (grant_active),
        .out    (mux_out)
    );

    // Load on a grant, drain when consumed with nothing to replace it.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant_active) begin
            state_d      = FULL;
            out_data_d   = mux_out;
            out_src_d    = grant;
            last_grant_d = grant;
            if (grant == CH0) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end else begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State register; last_grant resets to 1 so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            out_src_q    <= CH0;
            last_grant_q <= CH1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter.
// Expected output words are queued on accept and checked one cycle later.
module tb_mux_2x1_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] in0_data;
    logic        in0_valid;
    logic        in0_ready;
    logic [15:0] in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_src;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;

    int tests;
    int fails;
    logic [16:0] sb[$];

    mux_2x1_arbiter #(
        .WIDTH (16),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check readies, clock, check any accepted word.
    task automatic cyc(input logic v0, input logic [15:0] d0,
                       input logic v1, input logic [15:0] d1,
                       input logic ordy,
                       input logic er0, input logic er1);
        logic [16:0] e;
        logic        pushed;
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
        pushed    = 1'b0;
        #1;
        chk("in0_ready", 32'(in0_ready), 32'(er0));
        chk("in1_ready", 32'(in1_ready), 32'(er1));
        if (er0) begin
            sb.push_back({1'b0, d0});
            pushed = 1'b1;
        end
        if (er1) begin
            sb.push_back({1'b1, d1});
            pushed = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_data", 32'(out_data), 32'(e[15:0]));
                chk("out_src", 32'(out_src), 32'(e[16]));
            end
        end
    endtask

    task automatic do_reset();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 16'h1234;
        in1_valid = 1'b1;
        in1_data  = 16'h5678;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        rst = 1'b0;

        // Single channel-0 word
        cyc(1'b1, 16'hFFF0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        chk("t1_cnt0", 32'(cnt0), 32'd1);

        // Alternation from a fresh reset
        do_reset();
        cyc(1'b1, 16'h1111, 1'b1, 16'h0AAA, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 16'h1111, 1'b1, 16'h0AAA, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h1111, 1'b1, 16'h0AAA, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 16'h1111, 1'b1, 16'h0AAA, 1'b1, 1'b0, 1'b1);
        chk("alt_cnt0", 32'(cnt0), 32'd2);
        chk("alt_cnt1", 32'(cnt1), 32'd2);

        // Backpressure holding a channel-1 word
        cyc(1'b0, 16'h0, 1'b1, 16'h0AAA, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'h1111 + 16'(i), 1'b1, 16'h0BBB, 1'b0, 1'b0, 1'b0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h0AAA);
            chk("bp_out_src", 32'(out_src), 32'd1);
        end
        cyc(1'b1, 16'h1111, 1'b1, 16'h0BBB, 1'b1, 1'b1, 1'b0);
        chk("bp_cnt0", 32'(cnt0), 32'd3);
        chk("bp_cnt1", 32'(cnt1), 32'd3);

        // Channel 1 alone, counter wrap
        do_reset();
        for (int i = 0; i < 257; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 16'(i * 3 + 7), 1'b1, 1'b0, 1'b1);
            if (i == 255) begin
                chk("wrap_cnt1_zero", 32'(cnt1), 32'd0);
            end
        end
        chk("wrap_cnt1", 32'(cnt1), 32'd1);
        chk("wrap_cnt0", 32'(cnt0), 32'd0);

        // Reset while holding a word
        chk("pre_rst_full", 32'(out_valid), 32'd1);
        do_reset();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
        chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
        cyc(1'b1, 16'h1111, 1'b1, 16'h0AAA, 1'b1, 1'b1, 1'b0);

        // Drain with nothing pending
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_out_data", 32'(out_data), 32'h1111);
        chk("drain_out_src", 32'(out_src), 32'd0);

        // Idle while empty keeps the register empty
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
